// File: rtl/pdm_filter_ctrl.sv
// rtl/pdm_filter_ctrl.sv - PDM clock/capture front end and CIC filter warm-up sequencer
//
// Purpose:
//   Divides clk_i down to the PDM microphone clock, captures one mic bit per
//   PDM period as a single-cycle strobe toward the decimating filter, enables
//   the filter, drops its first WARMUP_SAMPLES output samples and forwards the
//   settled samples downstream.
//
// Ports:
//   clk_i            in   system clock
//   rst_n_i          in   synchronous reset, active low
//   en_i             in   block enable, level-sensitive
//   pdm_data_i       in   PDM bit from microphone
//   pdm_clk_o        out  PDM clock to microphone
//   filt_en_o        out  filter enable
//   filt_data_o      out  captured PDM bit to filter
//   filt_valid_o     out  1-cycle strobe, filt_data_o valid
//   filt_out_data_i  in   filter output sample, signed
//   filt_out_valid_i in   filter output strobe
//   data_o           out  settled sample, signed
//   valid_o          out  1-cycle strobe for data_o
//   ready_o          out  high while the block is in RUN

module pdm_filter_ctrl #(
    parameter int CLK_DIV        = 4,
    parameter int WARMUP_SAMPLES = 4,
    parameter int DATA_BW        = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               en_i,
    input  logic               pdm_data_i,
    output logic               pdm_clk_o,
    output logic               filt_en_o,
    output logic               filt_data_o,
    output logic               filt_valid_o,
    input  logic [DATA_BW-1:0] filt_out_data_i,
    input  logic               filt_out_valid_i,
    output logic [DATA_BW-1:0] data_o,
    output logic               valid_o,
    output logic               ready_o
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int WARM_W = $clog2(WARMUP_SAMPLES + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_SAMPLES - 1);
    localparam logic [WARM_W-1:0] WARM_FULL = WARM_W'(WARMUP_SAMPLES);

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [WARM_W-1:0]  warm_cnt;

    always_ff @(posedge clk_i) begin
        // Reset and enable drop share one path so that neither can leave a
        // partial sample or a stale strobe behind.
        if (!rst_n_i || !en_i) begin
            state        <= OFF;
            div_cnt      <= '0;
            warm_cnt     <= '0;
            pdm_clk_o    <= 1'b0;
            filt_en_o    <= 1'b0;
            filt_data_o  <= 1'b0;
            filt_valid_o <= 1'b0;
            data_o       <= '0;
            valid_o      <= 1'b0;
            ready_o      <= 1'b0;
        end else begin
            filt_valid_o <= 1'b0;
            valid_o      <= 1'b0;
            case (state)
                OFF: begin
                    state <= WARMUP;
                end
                WARMUP, RUN: begin
                    div_cnt   <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
                    pdm_clk_o <= (div_cnt < DIV_HALF);
                    filt_en_o <= 1'b1;
                    // Last cycle of the low phase: mic data has settled.
                    if (div_cnt == DIV_LAST) begin
                        filt_data_o  <= pdm_data_i;
                        filt_valid_o <= 1'b1;
                    end
                    if (state == WARMUP) begin
                        // The sample that completes warm-up is dropped too.
                        if (filt_out_valid_i) begin
                            if (warm_cnt == WARM_LAST) begin
                                warm_cnt <= WARM_FULL;
                                state    <= RUN;
                                ready_o  <= 1'b1;
                            end else begin
                                warm_cnt <= warm_cnt + 1'b1;
                            end
                        end
                    end else if (filt_out_valid_i) begin
                        data_o  <= filt_out_data_i;
                        valid_o <= 1'b1;
                    end
                end
                default: begin
                    state <= OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_filter_ctrl.sv
// tb/tb_pdm_filter_ctrl.sv - directed self-checking bench for pdm_filter_ctrl

module tb_pdm_filter_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 1: CLK_DIV=4, WARMUP_SAMPLES=4
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       pdm = 1'b0;
    logic       pdm_clk, filt_en, filt_data, filt_valid;
    logic [7:0] fod = 8'd0;
    logic       fov = 1'b0;
    logic [7:0] data;
    logic       valid, ready;

    // DUT 2: CLK_DIV=2, WARMUP_SAMPLES=1
    logic       rst_n2 = 1'b0;
    logic       en2 = 1'b1;
    logic       pdm2 = 1'b0;
    logic       pdm_clk2, filt_en2, filt_data2, filt_valid2;
    logic [7:0] fod2 = 8'd0;
    logic       fov2 = 1'b0;
    logic [7:0] data2;
    logic       valid2, ready2;

    pdm_filter_ctrl #(.CLK_DIV(4), .WARMUP_SAMPLES(4), .DATA_BW(8)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .pdm_data_i(pdm),
        .pdm_clk_o(pdm_clk), .filt_en_o(filt_en), .filt_data_o(filt_data),
        .filt_valid_o(filt_valid), .filt_out_data_i(fod),
        .filt_out_valid_i(fov), .data_o(data), .valid_o(valid), .ready_o(ready)
    );

    pdm_filter_ctrl #(.CLK_DIV(2), .WARMUP_SAMPLES(1), .DATA_BW(8)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n2), .en_i(en2), .pdm_data_i(pdm2),
        .pdm_clk_o(pdm_clk2), .filt_en_o(filt_en2), .filt_data_o(filt_data2),
        .filt_valid_o(filt_valid2), .filt_out_data_i(fod2),
        .filt_out_valid_i(fov2), .data_o(data2), .valid_o(valid2), .ready_o(ready2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        fov = 1'b1;
        fod = v;
        tick();
        fov = 1'b0;
        fod = 8'd0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".pdm_clk"},    32'(pdm_clk),    32'd0);
        check_eq({tag, ".filt_en"},    32'(filt_en),    32'd0);
        check_eq({tag, ".filt_valid"}, 32'(filt_valid), 32'd0);
        check_eq({tag, ".filt_data"},  32'(filt_data),  32'd0);
        check_eq({tag, ".data"},       32'(data),       32'd0);
        check_eq({tag, ".valid"},      32'(valid),      32'd0);
        check_eq({tag, ".ready"},      32'(ready),      32'd0);
    endtask

    // Warm-up sequence on DUT 1: four samples dropped, the fifth forwarded.
    task automatic warm_and_first(input string tag, input logic [7:0] base);
        for (int i = 0; i < 5; i++) begin
            send(base + 8'(i));
            check_eq({tag, ".ready"}, 32'(ready), (i >= 3) ? 32'd1 : 32'd0);
            check_eq({tag, ".valid"}, 32'(valid), (i == 4) ? 32'd1 : 32'd0);
            check_eq({tag, ".data"},  32'(data),  (i == 4) ? 32'(base + 8'd4) : 32'd0);
            tick();
        end
    endtask

    logic [3:0] pat;
    logic [7:0] samples  [6];
    logic [7:0] exp_data [6];
    int         idx;
    logic       exp_clk, exp_fv;

    initial begin
        pat      = 4'b1101;              // per-period bits 1,0,1,1 (index 0 first)
        samples  = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'hC4};
        exp_data = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd50, 8'hC4};

        // 1. Reset with en held high
        tick(); tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1;

        // 1/2. Clock division and capture pattern
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_clk = (k >= 2) && (((k - 2) % 4) < 2);
            exp_fv  = (k >= 5) && (((k - 5) % 4) == 0);
            check_eq("div.pdm_clk",    32'(pdm_clk),    32'(exp_clk));
            check_eq("div.filt_en",    32'(filt_en),    (k >= 2) ? 32'd1 : 32'd0);
            check_eq("cap.filt_valid", 32'(filt_valid), 32'(exp_fv));
            check_eq("warm.ready",     32'(ready),      32'd0);
            if (k >= 5) begin
                idx = (k - 5) / 4;
                check_eq("cap.filt_data", 32'(filt_data), 32'(pat[idx]));
            end
            // Correct bit only in the cycle before the capture edge.
            if (k >= 4 && (k - 4) / 4 <= 3) begin
                idx = (k - 4) / 4;
                pdm = ((k - 4) % 4 == 0) ? pat[idx] : ~pat[idx];
            end else begin
                pdm = 1'b0;
            end
        end

        // 3. Warm-up drop then forwarding
        for (int i = 0; i < 6; i++) begin
            send(samples[i]);
            check_eq("run.ready", 32'(ready), (i >= 3) ? 32'd1 : 32'd0);
            check_eq("run.valid", 32'(valid), (i >= 4) ? 32'd1 : 32'd0);
            check_eq("run.data",  32'(data),  32'(exp_data[i]));
            tick();
            check_eq("run.valid_drop", 32'(valid), 32'd0);
            check_eq("run.data_hold",  32'(data),  32'(exp_data[i]));
        end

        // 4. Enable drop in RUN, then re-enable
        tick();
        en = 1'b0;
        tick();
        check_all_zero("endrop");
        tick();
        check_eq("off.pdm_clk", 32'(pdm_clk), 32'd0);
        en = 1'b1;
        tick();
        check_eq("reen.filt_en0", 32'(filt_en), 32'd0);
        tick();
        check_eq("reen.filt_en1", 32'(filt_en), 32'd1);
        check_eq("reen.pdm_clk",  32'(pdm_clk), 32'd1);
        warm_and_first("reen", 8'd1);

        // 5a. Filter strobe coinciding with enable fall
        fov = 1'b1;
        fod = 8'd77;
        en  = 1'b0;
        tick();
        fov = 1'b0;
        check_eq("coinc.valid", 32'(valid), 32'd0);
        check_eq("coinc.data",  32'(data),  32'd0);
        check_eq("coinc.ready", 32'(ready), 32'd0);

        // 5b. Reset mid-warm-up with two samples already dropped
        en = 1'b1;
        tick(); tick();
        send(8'd1);
        send(8'd2);
        check_eq("midrst.ready", 32'(ready), 32'd0);
        rst_n = 1'b0;
        tick();
        check_all_zero("midrst");
        rst_n = 1'b1;
        tick();
        warm_and_first("midrst", 8'd11);

        // 6. CLK_DIV=2, WARMUP_SAMPLES=1
        pdm2   = 1'b1;
        rst_n2 = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check_eq("d2.pdm_clk",    32'(pdm_clk2),    (k >= 2 && (k % 2 == 0)) ? 32'd1 : 32'd0);
            check_eq("d2.filt_valid", 32'(filt_valid2), (k >= 3 && (k % 2 == 1)) ? 32'd1 : 32'd0);
            check_eq("d2.filt_en",    32'(filt_en2),    (k >= 2) ? 32'd1 : 32'd0);
        end
        check_eq("d2.filt_data", 32'(filt_data2), 32'd1);
        fov2 = 1'b1;
        fod2 = 8'd7;
        tick();
        check_eq("d2.ready1", 32'(ready2), 32'd1);
        check_eq("d2.valid1", 32'(valid2), 32'd0);
        fod2 = 8'd9;
        tick();
        fov2 = 1'b0;
        check_eq("d2.valid2", 32'(valid2), 32'd1);
        check_eq("d2.data2",  32'(data2),  32'd9);
        tick();
        check_eq("d2.valid3", 32'(valid2), 32'd0);
        check_eq("d2.hold",   32'(data2),  32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
